// File: rtl/jtag_dma_burst.sv
// DMA burst engine between the JTAG ping-pong buffer (system side) and the shared bus.
// Splits a command into bursts of up to MAX_BURST words, in both directions, with error abort.
module jtag_dma_burst #(
  parameter int BUFFER_DEPTH = 512,
  parameter int MAX_BURST    = 16,
  localparam int BA_W        = $clog2(BUFFER_DEPTH),
  localparam int CNT_W       = BA_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_read_n_write,
  input  logic [31:0]      cmd_address,
  input  logic [BA_W-1:0]  cmd_buffer_base,
  input  logic [CNT_W-1:0] cmd_word_count,
  input  logic [3:0]       cmd_byte_enable,
  output logic             done,
  output logic             status_error,
  output logic [CNT_W-1:0] words_done,
  output logic [BA_W-1:0]  buffer_address,
  output logic             buffer_write_enable,
  output logic [31:0]      buffer_data_out,
  input  logic [31:0]      buffer_data_in,
  output logic             request,
  input  logic             granted,
  output logic [31:0]      address_dataOUT,
  output logic [3:0]       byte_enableOUT,
  output logic [7:0]       burst_sizeOUT,
  output logic             read_n_writeOUT,
  output logic             begin_transactionOUT,
  output logic             end_transactionOUT,
  output logic             data_validOUT,
  output logic             busyOUT,
  input  logic [31:0]      address_dataIN,
  input  logic             end_transactionIN,
  input  logic             data_validIN,
  input  logic             busyIN,
  input  logic             errorIN
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RDATA, S_WFETCH, S_WDATA, S_WEND, S_NEXT, S_ERR, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_rnw;
  logic [31:0]      r_addr;
  logic [BA_W-1:0]  r_base;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_be;
  logic [CNT_W-1:0] r_words_done;
  logic [8:0]       r_beat;
  logic [8:0]       r_len;
  logic             r_status_error;
  logic             r_wr_en;
  logic [BA_W-1:0]  r_wr_addr;
  logic [31:0]      r_wr_data;

  logic [CNT_W-1:0] w_remaining;
  logic [31:0]      w_rem32;
  logic [8:0]       w_len;
  logic [BA_W-1:0]  w_idx;
  logic             w_accept;
  logic             w_rd_beat;

  assign w_remaining = r_count - r_words_done;
  assign w_rem32     = 32'(w_remaining);
  assign w_len       = (w_rem32 > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(w_rem32);
  assign w_idx       = r_base + r_words_done[BA_W-1:0];
  assign w_accept    = (r_state == S_WDATA) && !busyIN && !errorIN;
  assign w_rd_beat   = (r_state == S_RDATA) && data_validIN && (r_beat < r_len) && !errorIN;

  assign status_error        = r_status_error;
  assign words_done          = r_words_done;
  assign buffer_write_enable = r_wr_en;
  assign buffer_data_out     = r_wr_data;
  assign busyOUT             = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command/datapath registers; buffer writes land one cycle after the bus beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rnw          <= 1'b0;
      r_addr         <= 32'd0;
      r_base         <= '0;
      r_count        <= '0;
      r_be           <= 4'd0;
      r_words_done   <= '0;
      r_beat         <= 9'd0;
      r_len          <= 9'd0;
      r_status_error <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_rnw          <= cmd_read_n_write;
            r_addr         <= cmd_address;
            r_base         <= cmd_buffer_base;
            r_count        <= cmd_word_count;
            r_be           <= cmd_byte_enable;
            r_words_done   <= '0;
            r_status_error <= 1'b0;
          end
        end
        S_BEGIN: begin
          r_len  <= w_len;
          r_beat <= 9'd0;
          if (errorIN) r_status_error <= 1'b1;
        end
        S_RDATA: begin
          if (errorIN) begin
            r_status_error <= 1'b1;
          end else if (w_rd_beat) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= w_idx;
            r_wr_data    <= address_dataIN;
            r_words_done <= r_words_done + CNT_W'(1);
            r_beat       <= r_beat + 9'd1;
          end
        end
        S_WFETCH: begin
          if (errorIN) r_status_error <= 1'b1;
        end
        S_WDATA: begin
          if (errorIN) begin
            r_status_error <= 1'b1;
          end else if (w_accept) begin
            r_words_done <= r_words_done + CNT_W'(1);
            r_beat       <= r_beat + 9'd1;
          end
        end
        S_NEXT: begin
          r_addr <= r_addr + {21'd0, r_len, 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next         = r_state;
    cmd_ready            = 1'b0;
    done                 = 1'b0;
    request              = 1'b0;
    buffer_address       = r_wr_addr;
    address_dataOUT      = 32'd0;
    byte_enableOUT       = 4'd0;
    burst_sizeOUT        = 8'd0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = 1'b0;
    data_validOUT        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = (cmd_word_count == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        request = 1'b1;
        if (granted) w_state_next = S_BEGIN;
      end
      S_BEGIN: begin
        request              = 1'b1;
        begin_transactionOUT = 1'b1;
        address_dataOUT      = r_addr;
        burst_sizeOUT        = 8'(w_len - 9'd1);
        read_n_writeOUT      = r_rnw;
        byte_enableOUT       = r_be;
        if (errorIN)    w_state_next = S_ERR;
        else if (r_rnw) w_state_next = S_RDATA;
        else            w_state_next = S_WFETCH;
      end
      S_RDATA: begin
        request = 1'b1;
        if (errorIN)                w_state_next = S_ERR;
        else if (end_transactionIN) w_state_next = S_NEXT;
      end
      S_WFETCH: begin
        request        = 1'b1;
        buffer_address = w_idx;
        w_state_next   = errorIN ? S_ERR : S_WDATA;
      end
      S_WDATA: begin
        // Look one word ahead on accept so the synchronous buffer streams without bubbles.
        request         = 1'b1;
        data_validOUT   = 1'b1;
        address_dataOUT = buffer_data_in;
        buffer_address  = w_accept ? (w_idx + BA_W'(1)) : w_idx;
        if (errorIN)                                  w_state_next = S_ERR;
        else if (!busyIN && (r_beat == r_len - 9'd1)) w_state_next = S_WEND;
      end
      S_WEND: begin
        request            = 1'b1;
        end_transactionOUT = 1'b1;
        w_state_next       = S_NEXT;
      end
      S_NEXT: begin
        w_state_next = (w_remaining != '0) ? S_BEGIN : S_DONE;
      end
      S_ERR: begin
        end_transactionOUT = !r_rnw;
        w_state_next       = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtag_dma_burst.sv
// Scoreboard bench for jtag_dma_burst: stimulus pushes expected bus/buffer/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_jtag_dma_burst;
  localparam int DEPTH = 512;
  localparam int MB    = 16;
  localparam int BA_W  = 9;
  localparam int CNT_W = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_read_n_write = 1'b0;
  logic [31:0]      cmd_address = 32'd0;
  logic [BA_W-1:0]  cmd_buffer_base = '0;
  logic [CNT_W-1:0] cmd_word_count = '0;
  logic [3:0]       cmd_byte_enable = 4'd0;
  logic             done;
  logic             status_error;
  logic [CNT_W-1:0] words_done;
  logic [BA_W-1:0]  buffer_address;
  logic             buffer_write_enable;
  logic [31:0]      buffer_data_out;
  logic [31:0]      buffer_data_in;
  logic             request;
  logic             granted = 1'b1;
  logic [31:0]      address_dataOUT;
  logic [3:0]       byte_enableOUT;
  logic [7:0]       burst_sizeOUT;
  logic             read_n_writeOUT;
  logic             begin_transactionOUT;
  logic             end_transactionOUT;
  logic             data_validOUT;
  logic             busyOUT;
  logic [31:0]      address_dataIN = 32'd0;
  logic             end_transactionIN = 1'b0;
  logic             data_validIN = 1'b0;
  logic             busyIN = 1'b0;
  logic             errorIN = 1'b0;

  jtag_dma_burst #(.BUFFER_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read_n_write(cmd_read_n_write),
    .cmd_address(cmd_address), .cmd_buffer_base(cmd_buffer_base),
    .cmd_word_count(cmd_word_count), .cmd_byte_enable(cmd_byte_enable),
    .done(done), .status_error(status_error), .words_done(words_done),
    .buffer_address(buffer_address), .buffer_write_enable(buffer_write_enable),
    .buffer_data_out(buffer_data_out), .buffer_data_in(buffer_data_in),
    .request(request), .granted(granted),
    .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT),
    .burst_sizeOUT(burst_sizeOUT), .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN)
  );

  always #5 clock = ~clock;

  // Buffer model: synchronous read, pre-filled with 0xA500_0000 + index while init_mem is high.
  logic [31:0] mem [DEPTH];
  logic        init_mem = 1'b1;
  logic [31:0] rd_q = 32'd0;
  assign buffer_data_in = rd_q;
  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (buffer_write_enable) begin
      mem[buffer_address] <= buffer_data_out;
    end
    rd_q <= mem[buffer_address];
  end

  int total = 0;
  int bad   = 0;
  int n_end = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  logic [44:0] q_begin [$];
  logic [40:0] q_bufw  [$];
  logic [10:0] q_done  [$];
  logic [31:0] q_wdata [$];

  always @(negedge clock) begin
    if (begin_transactionOUT) begin
      if (q_begin.size() == 0) fail_evt("begin_unexpected");
      else chk("begin", 64'({address_dataOUT, burst_sizeOUT, read_n_writeOUT, byte_enableOUT}),
               64'(q_begin.pop_front()));
    end
    if (data_validOUT && !busyIN) begin
      if (q_wdata.size() == 0) fail_evt("wdata_unexpected");
      else chk("wdata", 64'(address_dataOUT), 64'(q_wdata.pop_front()));
    end
    if (data_validOUT && busyIN && q_wdata.size() > 0)
      chk("wdata_hold", 64'(address_dataOUT), 64'(q_wdata[0]));
    if (buffer_write_enable) begin
      if (q_bufw.size() == 0) fail_evt("bufw_unexpected");
      else chk("bufw", 64'({buffer_address, buffer_data_out}), 64'(q_bufw.pop_front()));
    end
    if (done) begin
      if (q_done.size() == 0) fail_evt("done_unexpected");
      else chk("done", 64'({words_done, status_error}), 64'(q_done.pop_front()));
    end
    if (end_transactionOUT) n_end++;
  end

  // Bus slave busy generator: stalls write beat busy_at for busy_left cycles.
  int wbeat = 0;
  int busy_at = -1;
  int busy_left = 0;
  bit force_busy = 1'b0;
  initial forever begin
    @(posedge clock);
    #1;
    if (force_busy) busyIN = 1'b1;
    else if (data_validOUT && wbeat == busy_at && busy_left > 0) begin
      busyIN = 1'b1;
      busy_left--;
    end else busyIN = 1'b0;
    if (data_validOUT && !busyIN) wbeat++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic rnw, input logic [31:0] addr, input int base, input int cnt,
                       input logic [3:0] be);
    cmd_read_n_write = rnw;
    cmd_address      = addr;
    cmd_buffer_base  = BA_W'(base);
    cmd_word_count   = CNT_W'(cnt);
    cmd_byte_enable  = be;
    cmd_valid        = 1'b1;
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    $display("cmd rnw=%0d addr=%08h base=%0d count=%0d", rnw, addr, base, cnt);
  endtask

  task automatic wait_begin();
    int n = 0;
    while (!begin_transactionOUT && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_evt("begin_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) fail_evt("done_timeout");
    step();
  endtask

  task automatic drive_read(input int n, input logic [31:0] d0, input int err_at);
    for (int k = 0; k < n; k++) begin
      if (k == err_at) begin
        errorIN = 1'b1;
        step();
        errorIN = 1'b0;
        return;
      end
      data_validIN      = 1'b1;
      address_dataIN    = d0 + 32'(k);
      end_transactionIN = (k == n - 1);
      step();
    end
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_request", 64'(request), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_words_done", 64'(words_done), 64'(0));
    chk("rst_status_error", 64'(status_error), 64'(0));
    chk("rst_bus", 64'({address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
        begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT, buffer_write_enable}),
        64'(0));
    reset = 1'b1;
    init_mem = 1'b0;
    step();

    // Read 5 words from 0x1000 into buffer[0..4]
    q_begin.push_back({32'h0000_1000, 8'd4, 1'b1, 4'hF});
    for (int i = 0; i < 5; i++) q_bufw.push_back({9'(i), 32'hD000_0000 + 32'(i)});
    q_done.push_back({10'd5, 1'b0});
    issue(1'b1, 32'h0000_1000, 0, 5, 4'hF);
    chk("t1_request_n1", 64'(request), 64'(1));
    step();
    chk("t1_begin_n2", 64'(begin_transactionOUT), 64'(1));
    step();
    drive_read(5, 32'hD000_0000, -1);
    wait_done();
    chk("t1_request_low", 64'(request), 64'(0));
    chk("t1_mem4", 64'(mem[4]), 64'(32'hD000_0004));

    // Write 40 words from buffer[16..55]: bursts 16/16/8
    q_begin.push_back({32'h0000_2000, 8'd15, 1'b0, 4'h3});
    q_begin.push_back({32'h0000_2040, 8'd15, 1'b0, 4'h3});
    q_begin.push_back({32'h0000_2080, 8'd7,  1'b0, 4'h3});
    for (int i = 0; i < 40; i++) q_wdata.push_back(32'hA500_0010 + 32'(i));
    q_done.push_back({10'd40, 1'b0});
    n_end = 0; wbeat = 0; busy_at = -1;
    issue(1'b0, 32'h0000_2000, 16, 40, 4'h3);
    wait_done();
    chk("t2_end_pulses", 64'(n_end), 64'(3));

    // Write 4 words with busy held 3 cycles on beat 2
    q_begin.push_back({32'h0000_3000, 8'd3, 1'b0, 4'hF});
    for (int i = 0; i < 4; i++) q_wdata.push_back(32'hA500_0064 + 32'(i));
    q_done.push_back({10'd4, 1'b0});
    n_end = 0; wbeat = 0; busy_at = 2; busy_left = 3;
    issue(1'b0, 32'h0000_3000, 100, 4, 4'hF);
    wait_done();
    chk("t3_end_pulses", 64'(n_end), 64'(1));
    chk("t3_busy_used", 64'(busy_left), 64'(0));
    busy_at = -1;

    // Read 8 with bus error on beat 3
    q_begin.push_back({32'h0000_4000, 8'd7, 1'b1, 4'hF});
    for (int i = 0; i < 3; i++) q_bufw.push_back({9'(200 + i), 32'hE000_0000 + 32'(i)});
    q_done.push_back({10'd3, 1'b1});
    n_end = 0;
    issue(1'b1, 32'h0000_4000, 200, 8, 4'hF);
    wait_begin();
    step();
    drive_read(8, 32'hE000_0000, 3);
    wait_done();
    chk("t4_error_sticky", 64'(status_error), 64'(1));
    chk("t4_no_end", 64'(n_end), 64'(0));
    chk("t4_mem202", 64'(mem[202]), 64'(32'hE000_0002));
    chk("t4_mem203_untouched", 64'(mem[203]), 64'(32'hA500_00CB));
    chk("t4_mem207_untouched", 64'(mem[207]), 64'(32'hA500_00CF));

    // Zero count: done next cycle, no request, error cleared
    q_done.push_back({10'd0, 1'b0});
    issue(1'b1, 32'h0000_5000, 0, 0, 4'hF);
    chk("t5_done_n1", 64'(done), 64'(1));
    chk("t5_error_cleared", 64'(status_error), 64'(0));
    chk("t5_no_request", 64'(request), 64'(0));
    step();
    chk("t5_no_request2", 64'(request), 64'(0));
    chk("t5_ready_back", 64'(cmd_ready), 64'(1));

    // Read 4 at base 510: wraps to indices 510, 511, 0, 1
    q_begin.push_back({32'h0000_6000, 8'd3, 1'b1, 4'hF});
    q_bufw.push_back({9'd510, 32'hF000_0000});
    q_bufw.push_back({9'd511, 32'hF000_0001});
    q_bufw.push_back({9'd0,   32'hF000_0002});
    q_bufw.push_back({9'd1,   32'hF000_0003});
    q_done.push_back({10'd4, 1'b0});
    issue(1'b1, 32'h0000_6000, 510, 4, 4'hF);
    wait_begin();
    step();
    drive_read(4, 32'hF000_0000, -1);
    wait_done();
    chk("t6_mem511", 64'(mem[511]), 64'(32'hF000_0001));
    chk("t6_mem1", 64'(mem[1]), 64'(32'hF000_0003));
    chk("t6_mem2_untouched", 64'(mem[2]), 64'(32'hD000_0002));

    // Reset asserted during WDATA
    force_busy = 1'b1;
    q_begin.push_back({32'h0000_7000, 8'd7, 1'b0, 4'hF});
    q_wdata.push_back(32'hA500_012C);
    n_end = 0;
    issue(1'b0, 32'h0000_7000, 300, 8, 4'hF);
    wait_begin();
    step();
    step();
    chk("t7_in_wdata", 64'(data_validOUT), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t7_rst_request", 64'(request), 64'(0));
    chk("t7_rst_bus", 64'({address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
        begin_transactionOUT, end_transactionOUT, data_validOUT}), 64'(0));
    step();
    reset = 1'b1;
    force_busy = 1'b0;
    q_wdata.delete();
    step();
    chk("t7_ready_after", 64'(cmd_ready), 64'(1));
    chk("t7_words_done", 64'(words_done), 64'(0));
    chk("t7_no_end", 64'(n_end), 64'(0));

    chk("left_begin", 64'(q_begin.size()), 64'(0));
    chk("left_bufw", 64'(q_bufw.size()), 64'(0));
    chk("left_done", 64'(q_done.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
